// File: rtl/shared_mem_arbiter.sv
`default_nettype none
//=============================================================================
//  Module      : shared_mem_arbiter
//  Description : Round-robin arbiter in front of a single-port data memory
//                shared by CORE_COUNT compute cores. One load/store is served
//                per grant (IDLE -> ACCESS -> RESP), and the granted core
//                receives a one-cycle completion pulse on core_val. Load data
//                is broadcast to all cores on core_rd_data.
//  Revision    : 1.0 - initial release
//=============================================================================

`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module shared_mem_arbiter #(
   parameter int CORE_COUNT = 4,
   parameter int ADDR_SIZE  = `ADDR_SIZE,
   parameter int REG_SIZE   = `REG_SIZE,
   parameter int MEM_DEPTH  = 1 << ADDR_SIZE
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2*CORE_COUNT-1:0]          core_enable,
   input  logic [ADDR_SIZE*CORE_COUNT-1:0]  core_addr,
   input  logic [REG_SIZE*CORE_COUNT-1:0]   core_wr_data,
   output logic [REG_SIZE-1:0]              core_rd_data,
   output logic [CORE_COUNT-1:0]            core_val,
   output logic                             busy
);

   localparam int                IDX_W      = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
   localparam int                MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [IDX_W-1:0]  LAST_CORE  = IDX_W'(CORE_COUNT - 1);
   localparam logic [IDX_W:0]    CORE_CNT_W = (IDX_W + 1)'(CORE_COUNT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   // Control and latched-request registers
   state_t                 state_q,  state_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]       grant_q,  grant_d;
   logic                   op_wr_q,  op_wr_d;
   logic [ADDR_SIZE-1:0]   addr_q,   addr_d;
   logic [REG_SIZE-1:0]    wdata_q,  wdata_d;
   logic [REG_SIZE-1:0]    rd_q;

   // Storage array; deliberately has no reset so contents survive reset
   logic [REG_SIZE-1:0]    mem_q [MEM_DEPTH];

   // Arbitration helpers
   logic [CORE_COUNT-1:0]    w_req;
   logic [2*CORE_COUNT-1:0]  w_req_dbl;
   logic [CORE_COUNT-1:0]    w_req_rot;
   logic                     w_found;
   logic [IDX_W-1:0]         w_offset;
   logic [IDX_W:0]           w_sum;
   logic [IDX_W-1:0]         w_winner;
   logic                     w_sel_wr;
   logic [ADDR_SIZE-1:0]     w_sel_addr;
   logic [REG_SIZE-1:0]      w_sel_wdata;

   // Memory access helpers
   logic                     w_in_range;
   logic [MEM_AW-1:0]        w_mem_idx;
   logic                     w_mem_wr;
   logic                     w_mem_rd;

   // A core requests when its enable pair is 01 (read) or 10 (write); 11 is idle
   generate
      for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_req
         assign w_req[gi] = core_enable[2*gi] ^ core_enable[2*gi+1];
      end
   endgenerate

   // Rotate the request vector so bit 0 is the core at rr_ptr; the lowest set
   // bit of the rotated vector is then the round-robin winner's offset.
   assign w_req_dbl = {w_req, w_req} >> rr_ptr_q;
   assign w_req_rot = w_req_dbl[CORE_COUNT-1:0];
   assign w_found   = |w_req;

   // Find the first requesting core at or after rr_ptr (offset from rr_ptr)
   always_comb begin
      w_offset = '0;
      for (int k = CORE_COUNT - 1; k >= 0; k--) begin
         if (w_req_rot[k]) begin
            w_offset = IDX_W'(k);
         end
      end
   end

   // Convert the offset back to an absolute core index, wrapping modulo CORE_COUNT
   assign w_sum    = {1'b0, rr_ptr_q} + {1'b0, w_offset};
   assign w_winner = (w_sum >= CORE_CNT_W) ? IDX_W'(w_sum - CORE_CNT_W)
                                           : w_sum[IDX_W-1:0];

   // Select the winning core's operation, address and store data
   always_comb begin
      w_sel_wr    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int k = 0; k < CORE_COUNT; k++) begin
         if (w_winner == IDX_W'(k)) begin
            w_sel_wr    = core_enable[2*k+1];
            w_sel_addr  = core_addr[k*ADDR_SIZE +: ADDR_SIZE];
            w_sel_wdata = core_wr_data[k*REG_SIZE +: REG_SIZE];
         end
      end
   end

   // Next-state logic: latch a winner in IDLE, one memory cycle, one response cycle
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      op_wr_d  = op_wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (w_found) begin
               grant_d = w_winner;
               op_wr_d = w_sel_wr;
               addr_d  = w_sel_addr;
               wdata_d = w_sel_wdata;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            // The core just served moves to the back of the search order
            rr_ptr_d = (grant_q == LAST_CORE) ? '0 : grant_q + IDX_W'(1);
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latched-request registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         op_wr_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         op_wr_q  <= op_wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   // Out-of-range accesses never touch the array
   assign w_in_range = (32'(addr_q) < 32'(MEM_DEPTH));
   assign w_mem_idx  = addr_q[MEM_AW-1:0];
   // A write whose ACCESS edge coincides with reset is aborted
   assign w_mem_wr   = reset && (state_q == S_ACCESS) && op_wr_q && w_in_range;
   assign w_mem_rd   = (state_q == S_ACCESS) && !op_wr_q;

   // Single-port memory write
   always_ff @(posedge clk) begin
      if (w_mem_wr) begin
         mem_q[w_mem_idx] <= wdata_q;
      end
   end

   // Read-data register; it doubles as the shared bus so writes leave it unchanged
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_q <= '0;
      end else if (w_mem_rd) begin
         rd_q <= w_in_range ? mem_q[w_mem_idx] : '0;
      end
   end

   // Completion pulse: one-hot on the granted core, only while in RESP
   generate
      for (genvar gv = 0; gv < CORE_COUNT; gv++) begin : g_val
         assign core_val[gv] = (state_q == S_RESP) && (grant_q == IDX_W'(gv));
      end
   endgenerate

   assign core_rd_data = rd_q;
   assign busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shared_mem_arbiter.sv
`default_nettype none
//=============================================================================
//  Module      : tb_shared_mem_arbiter
//  Description : Self-checking bench for shared_mem_arbiter. A transaction-
//                level reference model (pending set, round-robin pointer,
//                word array) predicts core_val, core_rd_data and busy each
//                cycle; directed steps cover reset, latency, ordering,
//                fairness, out-of-range and reset-abort, followed by
//                randomized traffic.
//  Revision    : 1.0 - initial release
//=============================================================================
module tb_shared_mem_arbiter;

   localparam int CC = 4;
   localparam int AW = 5;
   localparam int RW = 8;
   localparam int MD = 24;

   logic              clk = 1'b0;
   logic              reset;
   logic [2*CC-1:0]   en;
   logic [AW*CC-1:0]  addr;
   logic [RW*CC-1:0]  wdata;
   logic [RW-1:0]     rd;
   logic [CC-1:0]     val;
   logic              busy;

   always #5 clk = ~clk;

   shared_mem_arbiter #(
      .CORE_COUNT (CC),
      .ADDR_SIZE  (AW),
      .REG_SIZE   (RW),
      .MEM_DEPTH  (MD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .core_enable  (en),
      .core_addr    (addr),
      .core_wr_data (wdata),
      .core_rd_data (rd),
      .core_val     (val),
      .busy         (busy)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model state
   logic [RW-1:0] ref_mem [MD];
   int            ph;       // 0 idle, 1 memory cycle, 2 response cycle
   int            rr;
   int            m_core;
   logic          m_wr;
   int            m_addr;
   logic [RW-1:0] m_data;
   logic [RW-1:0] exp_rd;

   int            val_cyc [CC];
   logic [RW-1:0] got_rd  [CC];
   logic [CC-1:0] acked;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit pend(input int c);
      return (en[2*c +: 2] == 2'b01) || (en[2*c +: 2] == 2'b10);
   endfunction

   task automatic req(input int c, input logic [1:0] op, input int a, input logic [RW-1:0] d);
      en[2*c +: 2]     = op;
      addr[AW*c +: AW] = AW'(a);
      wdata[RW*c +: RW] = d;
   endtask

   // Advance the model over the coming clock edge using the inputs now driven
   task automatic model_edge();
      bit found;
      if (!reset) begin
         ph     = 0;
         rr     = 0;
         exp_rd = '0;
      end else begin
         case (ph)
            0: begin
               found = 1'b0;
               for (int k = 0; k < CC; k++) begin
                  if (!found && pend((rr + k) % CC)) begin
                     found  = 1'b1;
                     m_core = (rr + k) % CC;
                  end
               end
               if (found) begin
                  m_wr   = en[2*m_core+1];
                  m_addr = int'(addr[AW*m_core +: AW]);
                  m_data = wdata[RW*m_core +: RW];
                  ph     = 1;
               end
            end
            1: begin
               if (m_wr) begin
                  if (m_addr < MD) ref_mem[m_addr] = m_data;
               end else begin
                  exp_rd = (m_addr < MD) ? ref_mem[m_addr] : '0;
               end
               ph = 2;
            end
            default: begin
               rr = (m_core + 1) % CC;
               ph = 0;
            end
         endcase
      end
   endtask

   // One clock: predict, step, compare, record completions, release acked core
   task automatic tick();
      logic [CC-1:0] exp_val;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      exp_val = '0;
      if (ph == 2) exp_val[m_core] = 1'b1;
      chk("val", 32'(val), 32'(exp_val));
      chk("busy", 32'(busy), 32'(ph != 0));
      chk("rd_data", 32'(rd), 32'(exp_rd));
      for (int i = 0; i < CC; i++) begin
         if (val[i]) begin
            val_cyc[i] = cyc;
            got_rd[i]  = rd;
         end
      end
      if (ph == 2) begin
         en[2*m_core +: 2] = 2'b00;
         acked[m_core]     = 1'b1;
      end
   endtask

   initial begin
      int c0;
      int guard;
      int r;
      reset  = 1'b0;
      en     = '0;
      addr   = '0;
      wdata  = '0;
      ph     = 0;
      rr     = 0;
      m_core = 0;
      m_wr   = 1'b0;
      m_addr = 0;
      m_data = '0;
      exp_rd = '0;
      acked  = '0;
      for (int i = 0; i < CC; i++) begin
         val_cyc[i] = -1;
         got_rd[i]  = '0;
      end

      // Reset held two cycles, then release; enables of 11 must not start anything
      tick();
      tick();
      chk("rst_val", 32'(val), 32'h0);
      chk("rst_rd", 32'(rd), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      reset = 1'b1;
      en    = '1;
      repeat (3) tick();
      chk("idle_11_busy", 32'(busy), 32'h0);
      en = '0;

      // Give every in-range word a known value
      for (int a = 0; a < MD; a++) begin
         req(0, 2'b10, a, RW'($urandom));
         repeat (3) tick();
      end

      // Write then immediately re-requested read of the same word
      req(0, 2'b10, 5, 8'hA5);
      c0 = cyc;
      repeat (2) tick();
      chk("t2_wr_latency", val_cyc[0], c0 + 2);
      req(0, 2'b01, 5, 8'h00);
      c0 = cyc;
      repeat (3) tick();
      chk("t2_rd_latency", val_cyc[0], c0 + 3);
      chk("t2_rd_data", 32'(got_rd[0]), 32'hA5);

      // Reset brings rr_ptr to 0; all four cores read at once
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < CC; i++) req(i, 2'b01, 10 + i, 8'h00);
      c0 = cyc;
      repeat (11) tick();
      for (int i = 0; i < CC; i++) begin
         chk("t3_val_cycle", val_cyc[i], c0 + 2 + 3*i);
         chk("t3_rd_data", 32'(got_rd[i]), 32'(ref_mem[10 + i]));
      end

      // Core2 re-requests at once while core3 waits: core3 goes first
      tick();
      req(2, 2'b01, 3, 8'h00);
      req(3, 2'b01, 4, 8'h00);
      c0 = cyc;
      repeat (2) tick();
      chk("t4_core2_first", val_cyc[2], c0 + 2);
      req(2, 2'b01, 6, 8'h00);
      repeat (6) tick();
      chk("t4_core3_next", val_cyc[3], c0 + 5);
      chk("t4_core2_last", val_cyc[2], c0 + 8);

      // Out-of-range write is dropped and out-of-range read returns 0
      tick();
      req(1, 2'b10, MD, 8'h77);
      repeat (3) tick();
      req(1, 2'b01, MD, 8'h00);
      c0 = cyc;
      repeat (2) tick();
      chk("t5_val_cycle", val_cyc[1], c0 + 2);
      chk("t5_rd_zero", 32'(got_rd[1]), 32'h0);

      // Reset during the memory cycle of a write aborts it
      tick();
      req(0, 2'b10, 7, 8'h11);
      repeat (3) tick();
      req(0, 2'b10, 7, 8'h3C);
      val_cyc[0] = -1;
      tick();
      reset = 1'b0;
      en    = '0;
      tick();
      chk("t6_busy_after_rst", 32'(busy), 32'h0);
      reset = 1'b1;
      tick();
      chk("t6_no_val", val_cyc[0], -1);
      req(0, 2'b01, 7, 8'h00);
      repeat (2) tick();
      chk("t6_old_value", 32'(got_rd[0]), 32'h11);
      tick();

      // Randomized traffic including out-of-range addresses and 11 encodings
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < CC; c++) begin
            if (!pend(c) && !acked[c] && ($urandom_range(3) == 0)) begin
               r = $urandom_range(5);
               if (r < 2)      req(c, 2'b01, $urandom_range(31), 8'h00);
               else if (r < 4) req(c, 2'b10, $urandom_range(31), RW'($urandom));
               else if (r == 4) en[2*c +: 2] = 2'b11;
               else            en[2*c +: 2] = 2'b00;
            end
         end
         acked = '0;
         tick();
      end

      // Drain outstanding requests
      for (int c = 0; c < CC; c++) begin
         if (!pend(c)) en[2*c +: 2] = 2'b00;
      end
      guard = 0;
      while (((en != '0) || (ph != 0)) && (guard < 60)) begin
         tick();
         guard++;
      end
      chk("drain_in_time", 32'(guard < 60), 32'h1);
      chk("final_busy", 32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
